// File: rtl/task_fifo_bank.sv
// task_fifo_bank
//   Accepts push/pop task requests for TREE_NUM logical trees and queues them
//   into LEVEL task FIFOs (tree t -> FIFO t mod LEVEL), one per RPU. Each
//   FIFO entry is {type, treeId, data}. A pop for a tree with no outstanding
//   pushes is dropped and flagged for one cycle on o_task_drop.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_task_valid/o_task_ready, i_task_push, i_task_treeId, i_task_data
//                         task request handshake and contents
//   o_task_drop           one-cycle pulse after a dropped pop
//   i_pop_TaskFIFO        per-FIFO read strobe
//   o_TaskFIFO_data       per-FIFO registered read data
//   o_TaskFIFO_empty      per-FIFO empty flag

// Per-FIFO storage: circular buffer with registered read port.
//   clk, rst       clock, synchronous active-high reset
//   wr_en, wr_data write request (ignored while full)
//   rd_en          read request (ignored while empty)
//   rd_data        last entry read, held between reads
//   empty, full    occupancy flags from the registered count
module task_fifo_lane #(
    parameter int EW    = 19,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [EW-1:0] wr_data,
    input  logic          rd_en,
    output logic [EW-1:0] rd_data,
    output logic          empty,
    output logic          full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_wr, do_rd;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    // A full FIFO refuses a write even if a read frees a slot on the same edge.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage is not reset; pointers/count alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            // Read pointer never equals a same-edge write address while
            // count > 0 and not full, so the old entry is always read.
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module task_fifo_bank #(
    parameter int PTW           = 16,
    parameter int LEVEL         = 4,
    parameter int TREE_NUM      = 4,
    parameter int DEPTH         = 8,
    parameter int CNT_W         = 8,
    parameter int TREE_NUM_BITS = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic                                       i_task_valid,
    output logic                                       o_task_ready,
    input  logic                                       i_task_push,
    input  logic [TREE_NUM_BITS-1:0]                   i_task_treeId,
    input  logic [PTW-1:0]                             i_task_data,
    output logic                                       o_task_drop,
    input  logic [LEVEL-1:0]                           i_pop_TaskFIFO,
    output logic [LEVEL-1:0][PTW+TREE_NUM_BITS:0]      o_TaskFIFO_data,
    output logic [LEVEL-1:0]                           o_TaskFIFO_empty
);
    localparam int EW = PTW + TREE_NUM_BITS + 1;
    localparam int FW = (LEVEL > 1) ? $clog2(LEVEL) : 1;

    logic [TREE_NUM-1:0][CNT_W-1:0] tcnt;
    logic [CNT_W-1:0]               cur_tcnt;
    logic [31:0]                    tid_ext;
    logic [FW-1:0]                  fsel;
    logic [LEVEL-1:0]               lane_full;
    logic                           accept, enq, tcnt_zero;
    logic [EW-1:0]                  entry;

    assign tid_ext   = 32'(i_task_treeId);
    assign fsel      = FW'(tid_ext % 32'(LEVEL));
    assign cur_tcnt  = tcnt[i_task_treeId];
    assign tcnt_zero = (cur_tcnt == '0);

    // Ready does not depend on valid; a pop is blocked by a full FIFO even
    // when it would end up dropped.
    always_comb begin
        o_task_ready = 1'b1;
        if (i_rst)
            o_task_ready = 1'b0;
        else if (lane_full[fsel])
            o_task_ready = 1'b0;
        else if (i_task_push && (cur_tcnt == '1))
            o_task_ready = 1'b0;
    end

    assign accept = i_task_valid && o_task_ready;
    assign enq    = accept && (i_task_push || !tcnt_zero);
    assign entry  = {i_task_push, i_task_treeId, i_task_push ? i_task_data : PTW'(0)};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tcnt        <= '0;
            o_task_drop <= 1'b0;
        end else begin
            o_task_drop <= accept && !i_task_push && tcnt_zero;
            if (enq)
                tcnt[i_task_treeId] <= i_task_push ? cur_tcnt + CNT_W'(1)
                                                   : cur_tcnt - CNT_W'(1);
        end
    end

    for (genvar g = 0; g < LEVEL; g++) begin : g_lane
        task_fifo_lane #(.EW(EW), .DEPTH(DEPTH)) u_lane (
            .clk     (i_clk),
            .rst     (i_rst),
            .wr_en   (enq && (fsel == FW'(g))),
            .wr_data (entry),
            .rd_en   (i_pop_TaskFIFO[g]),
            .rd_data (o_TaskFIFO_data[g]),
            .empty   (o_TaskFIFO_empty[g]),
            .full    (lane_full[g])
        );
    end
endmodule
